id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/riscv_pkg.sv | 63 ++++++
 rtl/control_unit.sv | 52 +++++
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64 decode definitions: opcodes, ALU-op encodings, immediate formats,
// the control bundle carried through ID/EX and the immediate sign-extender.
package riscv_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_OP_ADD    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_FUNCT  = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2,
    IMM_SB   = 2'd3
  } imm_fmt_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    branch:     1'b0,
    alu_op:     ALU_OP_ADD
  };

  // Sign-extended immediate for the given format; formats without one yield 0.
  function automatic logic [XLEN-1:0] sext_imm(input logic [ILEN-1:0] instr,
                                               input imm_fmt_e fmt);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_SB:  imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Opcode-to-control mapping for the decode stage (purely combinational).
module control_unit
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl_c,
  output imm_fmt_e   imm_fmt_c,
  output logic       rs2_used_c,
  output logic       illegal_c
);

  always_comb begin
    ctrl_c     = CTRL_NOP;
    imm_fmt_c  = IMM_NONE;
    rs2_used_c = 1'b0;
    illegal_c  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_op    = ALU_OP_FUNCT;
        rs2_used_c       = 1'b1;
      end
      OP_I_ALU: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_OP_FUNCT;
        imm_fmt_c        = IMM_I;
      end
      OP_LOAD: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.alu_src    = 1'b1;
        imm_fmt_c         = IMM_I;
      end
      OP_STORE: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        imm_fmt_c        = IMM_S;
        rs2_used_c       = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.alu_op = ALU_OP_BRANCH;
        imm_fmt_c     = IMM_SB;
        rs2_used_c    = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// RV64 decode stage and ID/EX pipeline register with load-use stall and flush.
// Optional ID_EX_WB_BYPASS_EN forwards a same-cycle writeback into decode reads.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ILEN-1:0]   if_id_instr,
  input  logic              if_id_valid,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [XLEN-1:0]   ex_data1,
  output logic [XLEN-1:0]   ex_data2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_illegal,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op
);

  ctrl_t           dec_ctrl_c;
  imm_fmt_e        imm_fmt_c;
  logic            rs2_used_c;
  logic            illegal_c;
  logic            hazard_c;
  logic [XLEN-1:0] src1_c;
  logic [XLEN-1:0] src2_c;
  ctrl_t           ctrl_q;

  assign rs1 = if_id_instr[19:15];
  assign rs2 = if_id_instr[24:20];

  control_unit u_control_unit (
    .opcode     (if_id_instr[6:0]),
    .ctrl_c     (dec_ctrl_c),
    .imm_fmt_c  (imm_fmt_c),
    .rs2_used_c (rs2_used_c),
    .illegal_c  (illegal_c)
  );

  // Operand selection; x0 always reads as zero.
  always_comb begin
    src1_c = rd1;
    src2_c = rd2;
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1)) src1_c = wb_data;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2)) src2_c = wb_data;
`endif
    if (rs1 == '0) src1_c = '0;
    if (rs2 == '0) src2_c = '0;
  end

`ifndef ID_EX_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_rd, wb_data};
`endif

  // Load in EX whose destination is a source of the instruction in decode.
  assign hazard_c = ex_valid && ctrl_q.mem_read && (ex_rd != '0) && if_id_valid &&
                    ((ex_rd == rs1) || (rs2_used_c && (ex_rd == rs2)));

  assign stall = !reset && !flush && (hazard_c || !ex_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ctrl_q      <= CTRL_NOP;
      ex_illegal  <= 1'b0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_data1    <= '0;
      ex_data2    <= '0;
      ex_imm      <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      ex_illegal <= 1'b0;
    end else if (ex_ready) begin
      if (hazard_c) begin
        ex_valid   <= 1'b0;
        ctrl_q     <= CTRL_NOP;
        ex_illegal <= 1'b0;
      end else begin
        ex_valid    <= if_id_valid;
        ctrl_q      <= if_id_valid ? dec_ctrl_c : CTRL_NOP;
        ex_illegal  <= if_id_valid && illegal_c;
        ex_rd       <= if_id_instr[11:7];
        ex_rs1      <= rs1;
        ex_rs2      <= rs2;
        ex_data1    <= src1_c;
        ex_data2    <= src2_c;
        ex_imm      <= sext_imm(if_id_instr, imm_fmt_c);
        ex_funct3   <= if_id_instr[14:12];
        ex_funct7b5 <= if_id_instr[30];
      end
    end
  end

  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_branch     = ctrl_q.branch;
  assign ex_alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (bypass expectations follow ID_EX_WB_BYPASS_EN).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [4:0]  rs1, rs2;
  logic [63:0] rd1, rd2;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_ready, flush, stall;
  logic        ex_valid;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [63:0] ex_data1, ex_data2, ex_imm;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_illegal;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
  logic [1:0]  ex_alu_op;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I_LD   = 32'h0080B283; // ld   x5,8(x1)
  localparam logic [31:0] I_ADD  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_SD   = 32'hFE613C23; // sd   x6,-8(x2)
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3; // beq  x1,x2,-4
  localparam logic [31:0] I_ADDI = 32'hFFF00393; // addi x7,x0,-1
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [63:0] RD1    = 64'hAAAA_0000_0000_AAAA;
  localparam logic [63:0] RD2    = 64'hBBBB_0000_0000_BBBB;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_illegal(ex_illegal),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_alu_op(ex_alu_op)
  );

  always #5 clk = ~clk;

  // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op}
  function automatic logic [7:0] ctl_now();
    return {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_op};
  endfunction

  function automatic logic [299:0] all_regs();
    return {ex_valid, ex_rd, ex_rs1, ex_rs2, ex_data1, ex_data2, ex_imm, ex_funct3,
            ex_funct7b5, ex_illegal, ctl_now()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid);
    if_id_instr = instr;
    if_id_valid = valid;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b1; ex_ready = 1'b1;
    drive(I_LD, 1'b1);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    tick();
    checks++; if (all_regs() !== '0) begin failures++; $display("FAIL reset_regs got=%h exp=0", all_regs()); end
    reset = 1'b0; flush = 1'b0;
  endtask

  task automatic test_load();
    drive(I_LD, 1'b1);
    checks++; if ({rs1, rs2} !== {5'd1, 5'd8}) begin failures++; $display("FAIL load_rs got=%0d,%0d exp=1,8", rs1, rs2); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL load_stall got=%b exp=0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL load_valid got=%b exp=1", ex_valid); end
    checks++; if ({ex_rd, ex_rs1} !== {5'd5, 5'd1}) begin failures++; $display("FAIL load_regs got=%0d,%0d exp=5,1", ex_rd, ex_rs1); end
    checks++; if (ex_imm !== 64'd8) begin failures++; $display("FAIL load_imm got=%h exp=8", ex_imm); end
    checks++; if (ctl_now() !== 8'hD8) begin failures++; $display("FAIL load_ctl got=%h exp=d8", ctl_now()); end
    checks++; if (ex_data1 !== RD1 || ex_funct3 !== 3'd3) begin failures++; $display("FAIL load_data got=%h/%0d exp=%h/3", ex_data1, ex_funct3, RD1); end
  endtask

  task automatic test_load_use();
    drive(I_ADD, 1'b1);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    checks++; if ({ex_valid, ctl_now()} !== 9'h0) begin failures++; $display("FAIL lu_bubble got=%h exp=0", {ex_valid, ctl_now()}); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_clear got=%b exp=0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ctl_now() !== 8'h82) begin failures++; $display("FAIL lu_add_ctl got=%b/%h exp=1/82", ex_valid, ctl_now()); end
    checks++; if ({ex_rd, ex_rs1, ex_rs2} !== {5'd6, 5'd5, 5'd2}) begin failures++; $display("FAIL lu_add_regs got=%0d,%0d,%0d exp=6,5,2", ex_rd, ex_rs1, ex_rs2); end
    checks++; if (ex_imm !== 64'd0) begin failures++; $display("FAIL lu_add_imm got=%h exp=0", ex_imm); end
  endtask

  task automatic test_store();
    drive(I_SD, 1'b1);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sd_stall got=%b exp=0", stall); end
    tick();
    checks++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL sd_imm got=%h exp=fffffffffffffff8", ex_imm); end
    checks++; if (ctl_now() !== 8'h28) begin failures++; $display("FAIL sd_ctl got=%h exp=28", ctl_now()); end
    checks++; if ({ex_rs1, ex_rs2} !== {5'd2, 5'd6} || ex_data2 !== RD2) begin failures++; $display("FAIL sd_regs got=%0d,%0d,%h exp=2,6,%h", ex_rs1, ex_rs2, ex_data2, RD2); end
  endtask

  task automatic test_branch_and_x0();
    drive(I_BEQ, 1'b1);
    tick();
    checks++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL beq_imm got=%h exp=fffffffffffffffc", ex_imm); end
    checks++; if (ctl_now() !== 8'h05) begin failures++; $display("FAIL beq_ctl got=%h exp=05", ctl_now()); end
    drive(I_ADDI, 1'b1);
    tick();
    checks++; if (ctl_now() !== 8'h8A || ex_rd !== 5'd7) begin failures++; $display("FAIL addi_ctl got=%h/%0d exp=8a/7", ctl_now(), ex_rd); end
    checks++; if (ex_imm !== '1) begin failures++; $display("FAIL addi_imm got=%h exp=ffffffffffffffff", ex_imm); end
    checks++; if (ex_data1 !== 64'd0) begin failures++; $display("FAIL x0_data got=%h exp=0", ex_data1); end
  endtask

  task automatic test_illegal_invalid();
    drive(I_BAD, 1'b1);
    tick();
    checks++; if ({ex_valid, ex_illegal, ctl_now()} !== 10'h300) begin failures++; $display("FAIL illegal got=%h exp=300", {ex_valid, ex_illegal, ctl_now()}); end
    drive(I_LD, 1'b0);
    tick();
    checks++; if ({ex_valid, ex_illegal, ctl_now()} !== 10'h000) begin failures++; $display("FAIL invalid got=%h exp=0", {ex_valid, ex_illegal, ctl_now()}); end
  endtask

  task automatic test_hold_flush();
    drive(I_ADD, 1'b1);
    tick();
    drive(I_ADDI, 1'b1);
    ex_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, stall); end
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ctl_now() !== 8'h82) begin failures++; $display("FAIL hold_regs[%0d] got=%b/%0d/%h exp=1/6/82", i, ex_valid, ex_rd, ctl_now()); end
    end
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    tick();
    checks++; if ({ex_valid, ctl_now()} !== 9'h0) begin failures++; $display("FAIL flush_regs got=%h exp=0", {ex_valid, ctl_now()}); end
    flush = 1'b0;
    ex_ready = 1'b1;
  endtask

  task automatic test_bypass();
    logic [63:0] exp1;
`ifdef ID_EX_WB_BYPASS_EN
    exp1 = 64'h1234;
`else
    exp1 = RD1;
`endif
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234;
    drive(I_ADD, 1'b1);
    tick();
    checks++; if (ex_data1 !== exp1) begin failures++; $display("FAIL bypass_data1 got=%h exp=%h", ex_data1, exp1); end
    checks++; if (ex_data2 !== RD2) begin failures++; $display("FAIL bypass_data2 got=%h exp=%h", ex_data2, RD2); end
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = '0;
  endtask

  task automatic test_reset_bubble();
    drive(I_LD, 1'b1);
    tick();
    drive(I_ADD, 1'b1);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rb_pending got=%b exp=1", stall); end
    reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rb_stall got=%b exp=0", stall); end
    tick();
    checks++; if (all_regs() !== '0) begin failures++; $display("FAIL rb_regs got=%h exp=0", all_regs()); end
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rb_after got=%b exp=0", stall); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    if_id_instr = '0; if_id_valid = 1'b0;
    rd1 = RD1; rd2 = RD2;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    test_reset();
    test_load();
    test_load_use();
    test_store();
    test_branch_and_x0();
    test_illegal_invalid();
    test_hold_flush();
    test_bypass();
    test_reset_bubble();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
